// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge detector with one-deep pending slots,
// round-robin granted onto a single registered valid/ready event port.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_i,
  input  logic [NUM_CH-1:0] rise_en_i,
  input  logic [NUM_CH-1:0] fall_en_i,
  input  logic              clr_ovr_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [IDX_W-1:0]  evt_ch_o,
  output logic              evt_rise_o,
  output logic [NUM_CH-1:0] overrun_o
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  a_q;
  logic [NUM_CH-1:0]  pend_q, pend_d;
  logic [NUM_CH-1:0]  pend_rise_q, pend_rise_d;
  logic [NUM_CH-1:0]  ovr_q, ovr_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   ch_q, ch_d;
  logic               rise_q, rise_d;

  logic [NUM_CH-1:0]  rise, fall, evt;
  logic [NUM_CH-1:0]  load_mask, held, accept;
  logic               load;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_ch;
  logic [IDX_W-1:0]   idx;

  assign rise = a_i & ~a_q & rise_en_i;
  assign fall = ~a_i & a_q & fall_en_i;
  assign evt  = rise | fall;

  // First pending channel strictly after the last granted one, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!sel_found && pend_q[idx]) begin
        sel_found = 1'b1;
        sel_ch    = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rise_d   = rise_q;
    rr_ptr_d = rr_ptr_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) load = 1'b1;
      end
      OFFER: begin
        if (evt_ready_i) begin
          if (sel_found) load = 1'b1;
          else           state_d = IDLE;
        end
      end
    endcase
    if (load) begin
      state_d  = OFFER;
      ch_d     = sel_ch;
      rise_d   = pend_rise_q[sel_ch];
      rr_ptr_d = sel_ch;
    end
  end

  // A slot being loaded this cycle is free again, so a same-cycle event refills it.
  always_comb begin
    load_mask   = load ? (NUM_CH'(1) << sel_ch) : '0;
    held        = pend_q & ~load_mask;
    accept      = evt & ~held;
    pend_d      = held | evt;
    pend_rise_d = (pend_rise_q & ~accept) | (rise & accept);
    ovr_d       = (ovr_q & ~{NUM_CH{clr_ovr_i}}) | (evt & held);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      pend_q      <= '0;
      pend_rise_q <= '0;
      ovr_q       <= '0;
      rr_ptr_q    <= IDX_W'(NUM_CH - 1);
      ch_q        <= '0;
      rise_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_i;
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      ovr_q       <= ovr_d;
      rr_ptr_q    <= rr_ptr_d;
      ch_q        <= ch_d;
      rise_q      <= rise_d;
    end
  end

  assign evt_valid_o = (state_q == OFFER);
  assign evt_ch_o    = ch_q;
  assign evt_rise_o  = rise_q;
  assign overrun_o   = ovr_q;

endmodule
